rv_elastic_buffer: RTL and testbench

- Two-slot elastic buffer (register slice) for a valid/ready channel inside the AXI4 NoC.
- Sits directly upstream of the ready/valid handshake checker and drives the data/valid/ready channel that checker monitors.
- Breaks the combinational path on data, valid and ready with no bubbles: full throughput of one beat per cycle, one cycle of latency.
- Output side obeys the handshake rules by construction: once out_valid is raised, it and out_data stay stable until out_ready.

---
 rtl/rv_elastic_buffer.sv | 76 +++++++
 tb/tb_rv_elastic_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv_elastic_buffer.sv
// Two-slot elastic buffer (register slice) for a valid/ready channel.
// Registers data, valid and ready with full throughput and one cycle of latency.
module rv_elastic_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  push;
  logic                  pop;

  // Flags come from the state register only, so ready/valid paths stay registered.
  assign in_ready  = (state_q != TWO) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: the data registers are reset too, so out_data reads 0 after reset
  // rather than whatever was left behind; all state uses non-blocking <= so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_q <= ONE;
            main_q  <= in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in_data;
          end else if (push) begin
            state_q <= TWO;
            skid_q  <= in_data;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop) begin
            state_q <= ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// Self-checking bench for rv_elastic_buffer: an occupancy model plus a FIFO
// scoreboard filled on accepted input beats and drained on output handshakes.
module tb_rv_elastic_buffer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occupancy;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  int            occ_m = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          last_push = 1'b0;

  rv_elastic_buffer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; sample mid-cycle, update the
  // model and scoreboard, then advance to just after the rising edge.
  task automatic cycle();
    logic exp_push;
    logic exp_pop;
    @(negedge clk);
    exp_push = in_valid && (occ_m != 2);
    exp_pop  = (occ_m != 0) && out_ready;
    check("occupancy", 64'(occupancy), 64'(occ_m));
    check("in_ready", 64'(in_ready), 64'(occ_m != 2));
    check("out_valid", 64'(out_valid), 64'(occ_m != 0));
    if (hold_prev) check("hold_data", 64'(out_data), 64'(prev_data));
    if (exp_pop && sb.size() > 0) check("sb_data", 64'(out_data), 64'(sb.pop_front()));
    hold_prev = (occ_m != 0) && !out_ready;
    prev_data = out_data;
    if (exp_push) sb.push_back(in_data);
    occ_m     = occ_m + int'(exp_push) - int'(exp_pop);
    last_push = exp_push;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    occ_m     = 0;
    hold_prev = 1'b0;
    last_push = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] payload;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Streaming with the sink always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    cycle();
    check("latency_data", 64'(out_data), 64'h1);
    in_data = 32'h2;
    cycle();
    in_data = 32'h3;
    cycle();
    in_valid = 1'b0;
    cycle();

    // Backpressure fill: A then B, C offered but refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    cycle();
    in_data = 32'hB;
    cycle();
    in_data = 32'hC;
    cycle();
    cycle();
    check("full_data", 64'(out_data), 64'hA);
    check("full_occupancy", 64'(occupancy), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);

    // Drain from full: A, B, then C once space opens.
    out_ready = 1'b1;
    cycle();
    cycle();
    check("drain_c_taken", 64'(last_push), 64'd1);
    in_valid = 1'b0;
    cycle();
    check("drain_empty", 64'(occupancy), 64'd0);

    // Simultaneous push and pop while holding one beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    cycle();
    out_ready = 1'b1;
    in_data   = 32'h6;
    cycle();
    check("pushpop_data", 64'(out_data), 64'h6);
    check("pushpop_occupancy", 64'(occupancy), 64'd1);
    in_valid = 1'b0;
    cycle();

    // Random valid/ready with an incrementing payload.
    payload = 32'h100;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      in_data   = payload;
      cycle();
      if (last_push) payload = payload + 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    check("random_drained", 64'(sb.size()), 64'd0);

    // Reset mid-operation with the buffer full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD0;
    cycle();
    in_data = 32'hD1;
    cycle();
    check("prereset_full", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_occupancy", 64'(occupancy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    check("rst_held_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    in_data   = 32'h77;
    cycle();
    check("post_rst_first", 64'(out_data), 64'h77);
    in_valid = 1'b0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
